// File: rtl/mod_writeback_rf.sv
// Writeback stage with integrated registered register file, busy scoreboard and retire counter.
// Latency: register write visible one cycle after transfer, zero cycles through the read bypass.
// Backpressure: ex_ready is high only in IDLE; a store stalls EX until st_ack, sim_end halts forever.
//
// Ports:
//   clk, reset                        clock, asynchronous active-high reset
//   ex_valid/ex_ready                 EX result handshake (transfer = ex_valid & ex_ready)
//   ex_dst{0,1}_en/ex_dst{0,1}/ex_data{0,1}
//                                     up to two register writes per instruction, dst1 wins on collision
//   ex_is_store, ex_sim_end           store (held until st_ack), last instruction of the program
//   st_req/st_ack                     store commit handshake with the memory stage
//   rd_idx_{a,b}/rd_data_{a,b}        combinational read ports with same-cycle write bypass
//   busy_set_en/busy_set_idx, busy    scoreboard: decode sets, writeback clears, set wins
//   retire_count, sim_done            retired instruction count, halted after sim_end retires
module mod_writeback_rf #(
   parameter int DATA_W    = 64,
   parameter int NUM_REGS  = 16,
   parameter int REG_IDX_W = 4,
   parameter int CNT_W     = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ex_valid,
   output logic                 ex_ready,
   input  logic                 ex_dst0_en,
   input  logic [REG_IDX_W-1:0] ex_dst0,
   input  logic [DATA_W-1:0]    ex_data0,
   input  logic                 ex_dst1_en,
   input  logic [REG_IDX_W-1:0] ex_dst1,
   input  logic [DATA_W-1:0]    ex_data1,
   input  logic                 ex_is_store,
   input  logic                 ex_sim_end,
   output logic                 st_req,
   input  logic                 st_ack,
   input  logic [REG_IDX_W-1:0] rd_idx_a,
   output logic [DATA_W-1:0]    rd_data_a,
   input  logic [REG_IDX_W-1:0] rd_idx_b,
   output logic [DATA_W-1:0]    rd_data_b,
   input  logic                 busy_set_en,
   input  logic [REG_IDX_W-1:0] busy_set_idx,
   output logic [NUM_REGS-1:0]  busy,
   output logic [CNT_W-1:0]     retire_count,
   output logic                 sim_done
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT_ST = 2'd1,
      S_HALTED  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                end_q, end_d;
   logic [CNT_W-1:0]    retire_q, retire_d;
   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic [DATA_W-1:0]   rf_q [NUM_REGS];
   logic [DATA_W-1:0]   rf_d [NUM_REGS];

   logic xfer;
   logic wr0, wr1;
   logic retire_en;

   // ex_ready is only high in IDLE, so every write/bypass below is implicitly IDLE-only.
   assign xfer      = ex_valid & ex_ready;
   assign wr0       = xfer & ~ex_is_store & ex_dst0_en;
   assign wr1       = xfer & ~ex_is_store & ex_dst1_en;
   assign retire_en = (xfer & ~ex_is_store) | ((state_q == S_WAIT_ST) & st_ack);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (xfer) begin
               if (ex_is_store)     state_d = S_WAIT_ST;
               else if (ex_sim_end) state_d = S_HALTED;
            end
         end
         S_WAIT_ST: begin
            if (st_ack) state_d = end_q ? S_HALTED : S_IDLE;
         end
         S_HALTED: state_d = S_HALTED;
         default:  state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      ex_ready = 1'b0;
      st_req   = 1'b0;
      sim_done = 1'b0;
      case (state_q)
         S_IDLE:    ex_ready = 1'b1;
         S_WAIT_ST: st_req   = 1'b1;
         S_HALTED:  sim_done = 1'b1;
         default:   ex_ready = 1'b0;
      endcase
   end

   // ---------------- datapath next state ----------------
   always_comb begin
      end_d    = end_q;
      retire_d = retire_q;
      if (xfer && ex_is_store) end_d = ex_sim_end;
      if (retire_en)           retire_d = retire_q + CNT_W'(1);
   end

   // Out-of-range indices match no entry, so writes and busy sets to them drop out naturally.
   // dst1 is applied after dst0 so it wins when both target the same register.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         rf_d[i] = rf_q[i];
         if (wr0 && (ex_dst0 == REG_IDX_W'(i))) rf_d[i] = ex_data0;
         if (wr1 && (ex_dst1 == REG_IDX_W'(i))) rf_d[i] = ex_data1;
      end
   end

   // Set beats clear so a re-issued producer stays pending past the older writeback.
   always_comb begin
      busy_d = busy_q;
      for (int i = 0; i < NUM_REGS; i++) begin
         if ((wr0 && (ex_dst0 == REG_IDX_W'(i))) || (wr1 && (ex_dst1 == REG_IDX_W'(i))))
            busy_d[i] = 1'b0;
         if (busy_set_en && (busy_set_idx == REG_IDX_W'(i)))
            busy_d[i] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         end_q    <= 1'b0;
         retire_q <= '0;
         busy_q   <= '0;
         for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
      end else begin
         end_q    <= end_d;
         retire_q <= retire_d;
         busy_q   <= busy_d;
         for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= rf_d[i];
      end
   end

   // ---------------- read ports with write bypass ----------------
   always_comb begin
      rd_data_a = '0;
      if (int'(rd_idx_a) < NUM_REGS) begin
         if (wr1 && (ex_dst1 == rd_idx_a))      rd_data_a = ex_data1;
         else if (wr0 && (ex_dst0 == rd_idx_a)) rd_data_a = ex_data0;
         else                                   rd_data_a = rf_q[rd_idx_a];
      end
   end

   always_comb begin
      rd_data_b = '0;
      if (int'(rd_idx_b) < NUM_REGS) begin
         if (wr1 && (ex_dst1 == rd_idx_b))      rd_data_b = ex_data1;
         else if (wr0 && (ex_dst0 == rd_idx_b)) rd_data_b = ex_data0;
         else                                   rd_data_b = rf_q[rd_idx_b];
      end
   end

   assign busy         = busy_q;
   assign retire_count = retire_q;

endmodule

// File: tb/tb_mod_writeback_rf.sv
// Directed bench for mod_writeback_rf; NUM_REGS=12 so out-of-range indices exist.
// Inputs change 1 ns after the rising edge, outputs are checked 2 ns after it.
// All expected values are hand-computed constants.
module tb_mod_writeback_rf;

   localparam int DATA_W    = 64;
   localparam int NUM_REGS  = 12;
   localparam int REG_IDX_W = 4;
   localparam int CNT_W     = 32;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 ex_valid;
   logic                 ex_ready;
   logic                 ex_dst0_en;
   logic [REG_IDX_W-1:0] ex_dst0;
   logic [DATA_W-1:0]    ex_data0;
   logic                 ex_dst1_en;
   logic [REG_IDX_W-1:0] ex_dst1;
   logic [DATA_W-1:0]    ex_data1;
   logic                 ex_is_store;
   logic                 ex_sim_end;
   logic                 st_req;
   logic                 st_ack;
   logic [REG_IDX_W-1:0] rd_idx_a;
   logic [DATA_W-1:0]    rd_data_a;
   logic [REG_IDX_W-1:0] rd_idx_b;
   logic [DATA_W-1:0]    rd_data_b;
   logic                 busy_set_en;
   logic [REG_IDX_W-1:0] busy_set_idx;
   logic [NUM_REGS-1:0]  busy;
   logic [CNT_W-1:0]     retire_count;
   logic                 sim_done;

   int n_checks = 0;
   int n_fail   = 0;

   mod_writeback_rf #(
      .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .REG_IDX_W(REG_IDX_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_dst0_en(ex_dst0_en), .ex_dst0(ex_dst0), .ex_data0(ex_data0),
      .ex_dst1_en(ex_dst1_en), .ex_dst1(ex_dst1), .ex_data1(ex_data1),
      .ex_is_store(ex_is_store), .ex_sim_end(ex_sim_end),
      .st_req(st_req), .st_ack(st_ack),
      .rd_idx_a(rd_idx_a), .rd_data_a(rd_data_a),
      .rd_idx_b(rd_idx_b), .rd_data_b(rd_data_b),
      .busy_set_en(busy_set_en), .busy_set_idx(busy_set_idx), .busy(busy),
      .retire_count(retire_count), .sim_done(sim_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clr_in();
      ex_valid = 0; ex_dst0_en = 0; ex_dst0 = 0; ex_data0 = 0;
      ex_dst1_en = 0; ex_dst1 = 0; ex_data1 = 0;
      ex_is_store = 0; ex_sim_end = 0; st_ack = 0;
      busy_set_en = 0; busy_set_idx = 0;
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a single-destination instruction (not yet clocked).
   task automatic drive_op(input logic [3:0] d0, input logic [63:0] v0, input logic last);
      ex_valid = 1; ex_dst0_en = 1; ex_dst0 = d0; ex_data0 = v0; ex_sim_end = last;
   endtask

   initial begin
      clr_in();
      rd_idx_a = 0; rd_idx_b = 0;
      reset = 1;
      repeat (2) tick();
      #1;
      // ---- reset state ----
      chk("rst_retire", retire_count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_st_req", st_req, 0);
      chk("rst_sim_done", sim_done, 0);
      chk("rst_reg0", rd_data_a, 0);
      reset = 0;
      tick();

      // ---- single write with bypass, busy clear ----
      busy_set_en = 1; busy_set_idx = 3;
      tick();
      clr_in();
      #1 chk("busy3_set", busy, 12'h008);
      drive_op(4'd3, 64'h1234, 0);
      rd_idx_a = 3;
      #1 chk("bypass_r3", rd_data_a, 64'h1234);
      chk("ready_idle", ex_ready, 1);
      tick();
      clr_in();
      #1 chk("reg3", rd_data_a, 64'h1234);
      chk("busy3_clr", busy, 0);
      chk("retire1", retire_count, 1);

      // ---- dual destination (0xF7 style) ----
      ex_valid = 1; ex_dst0_en = 1; ex_dst0 = 0; ex_data0 = 64'hAA;
      ex_dst1_en = 1; ex_dst1 = 2; ex_data1 = 64'hBB;
      rd_idx_a = 0; rd_idx_b = 2;
      #1 chk("bypass_r0", rd_data_a, 64'hAA);
      chk("bypass_r2", rd_data_b, 64'hBB);
      tick();
      clr_in();
      #1 chk("reg0", rd_data_a, 64'hAA);
      chk("reg2", rd_data_b, 64'hBB);
      chk("retire2", retire_count, 2);
      // dst0 == dst1: dst1 wins
      ex_valid = 1; ex_dst0_en = 1; ex_dst0 = 5; ex_data0 = 64'hCC;
      ex_dst1_en = 1; ex_dst1 = 5; ex_data1 = 64'hBB;
      rd_idx_a = 5;
      #1 chk("bypass_coll_r5", rd_data_a, 64'hBB);
      tick();
      clr_in();
      #1 chk("coll_reg5", rd_data_a, 64'hBB);
      chk("retire3", retire_count, 3);

      // ---- store held 3 cycles ----
      busy_set_en = 1; busy_set_idx = 7;
      tick();
      clr_in();
      drive_op(4'd7, 64'h77, 0);
      ex_is_store = 1;
      rd_idx_a = 7;
      #1 chk("store_no_bypass", rd_data_a, 0);
      tick();
      clr_in();
      for (int c = 0; c < 3; c++) begin
         // attempted transfer while waiting must be ignored
         drive_op(4'd8, 64'h88, 0);
         rd_idx_b = 8;
         st_ack = (c == 2);
         #1 chk($sformatf("wst_req_c%0d", c), st_req, 1);
         chk($sformatf("wst_ready_c%0d", c), ex_ready, 0);
         chk($sformatf("wst_retire_c%0d", c), retire_count, 3);
         chk($sformatf("wst_nobyp_c%0d", c), rd_data_b, 0);
         tick();
      end
      clr_in();
      #1 chk("st_req_drop", st_req, 0);
      chk("st_ready_back", ex_ready, 1);
      chk("retire4", retire_count, 4);
      chk("reg7_unwritten", rd_data_a, 0);
      chk("reg8_unwritten", rd_data_b, 0);
      chk("busy7_kept", busy, 12'h080);
      // st_ack in IDLE ignored
      st_ack = 1;
      tick();
      clr_in();
      #1 chk("idle_ack_retire", retire_count, 4);
      chk("idle_ack_st_req", st_req, 0);

      // ---- busy set and clear same cycle on reg4 ----
      busy_set_en = 1; busy_set_idx = 4;
      drive_op(4'd4, 64'h44, 0);
      tick();
      clr_in();
      rd_idx_a = 4;
      #1 chk("busy_set_wins", busy, 12'h090);
      chk("reg4", rd_data_a, 64'h44);
      chk("retire5", retire_count, 5);

      // ---- out-of-range index 13 ----
      busy_set_en = 1; busy_set_idx = 13;
      drive_op(4'd13, 64'hDD, 0);
      ex_dst1_en = 1; ex_dst1 = 1; ex_data1 = 64'h11;
      rd_idx_a = 13; rd_idx_b = 1;
      #1 chk("oor_bypass_zero", rd_data_a, 0);
      tick();
      clr_in();
      #1 chk("oor_read_zero", rd_data_a, 0);
      chk("oor_busy_ign", busy, 12'h090);
      chk("reg1", rd_data_b, 64'h11);
      chk("retire6", retire_count, 6);

      // ---- reset in the middle of WAIT_ST ----
      ex_valid = 1; ex_is_store = 1;
      tick();
      clr_in();
      rd_idx_a = 4;
      #1 chk("pre_rst_st_req", st_req, 1);
      reset = 1;
      #1 chk("mid_rst_st_req", st_req, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_retire", retire_count, 0);
      chk("mid_rst_reg4", rd_data_a, 0);
      reset = 0;
      #1 chk("post_rst_ready", ex_ready, 1);
      tick();

      // ---- sim_end on the 10th instruction ----
      for (int k = 0; k < 10; k++) begin
         drive_op(4'(k), 64'h100 + 64'(k), (k == 9));
         tick();
      end
      clr_in();
      rd_idx_a = 9; rd_idx_b = 2;
      #1 chk("halt_sim_done", sim_done, 1);
      chk("halt_retire10", retire_count, 10);
      chk("halt_ready", ex_ready, 0);
      chk("halt_reg9", rd_data_a, 64'h109);
      drive_op(4'd2, 64'h99, 0);
      #1 chk("halt_no_bypass", rd_data_b, 64'h102);
      tick();
      clr_in();
      #1 chk("halt_reg2_kept", rd_data_b, 64'h102);
      chk("halt_retire_kept", retire_count, 10);
      chk("halt_still_done", sim_done, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
